// File: rtl/jk_counter_pkg.sv
// ============================================================================
// Module      : jk_counter_pkg
// Description : Shared direction codes, the all-ones helper and the JK mode
//               enum for the JK-cell up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jk_counter_pkg;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Encoding matches {j, k}, so a cell can cast its inputs directly.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_mode_t;

  function automatic logic [63:0] all_ones(input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_ff_cell.sv
// ============================================================================
// Module      : jk_ff_cell
// Description : Single-bit edge-triggered JK flip-flop, async active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_ff_cell
  import jk_counter_pkg::*;
(
  input  logic clk,
  input  logic CLR_N,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  logic r_q;

  always_ff @(posedge clk or negedge CLR_N) begin
    if (!CLR_N) begin
      r_q <= 1'b0;
    end else begin
      case (jk_mode_t'({j, k}))
        JK_HOLD:   r_q <= r_q;
        JK_RESET:  r_q <= 1'b0;
        JK_SET:    r_q <= 1'b1;
        JK_TOGGLE: r_q <= ~r_q;
        default:   r_q <= r_q;
      endcase
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

`default_nettype wire

// File: rtl/jk_sync_updown_counter.sv
// ============================================================================
// Module      : jk_sync_updown_counter
// Description : Presettable synchronous up/down counter of WIDTH JK cells with
//               carry/borrow look-ahead; cascadable through max_min and tc.
//               Define COUNTER_SATURATE_EN to stop at the terminal value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_sync_updown_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             CLR_N,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             dn_up,
  output logic [WIDTH-1:0] q,
  output logic             max_min,
  output logic             tc
);

  localparam logic [63:0] C_ONES = all_ones(WIDTH);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qbar;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_t;
  logic             w_max_min;
  logic             w_sat;

  assign w_max_min = (dn_up == DIR_DN) ? (w_q == '0)
                                       : (w_q == C_ONES[WIDTH-1:0]);

`ifdef COUNTER_SATURATE_EN
  assign w_sat = w_max_min;
`else
  assign w_sat = 1'b0;
`endif

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
        assign w_t[i] = en & ~w_sat;
      end else begin : g_upper
        // Toggle when every lower bit is 1 (up) or 0 (down).
        assign w_t[i] = en & ~w_sat &
                        ((dn_up == DIR_DN) ? (&w_qbar[i-1:0]) : (&w_q[i-1:0]));
      end

      assign w_j[i] = load ? d[i]  : w_t[i];
      assign w_k[i] = load ? ~d[i] : w_t[i];

      jk_ff_cell u_cell (
        .clk  (clk),
        .CLR_N(CLR_N),
        .j    (w_j[i]),
        .k    (w_k[i]),
        .q    (w_q[i]),
        .qbar (w_qbar[i])
      );
    end
  endgenerate

  assign q       = w_q;
  assign max_min = w_max_min;
  assign tc      = w_max_min & en;

endmodule

`default_nettype wire
